// File: rtl/cmd_host_master_pkg.sv
// -----------------------------------------------------------------------------
// cmd_host_master_pkg
// Shared definitions for the host-side command-frame initiator:
//   - frame header bytes for each command type
//   - op_e    : command opcode (2 bits, matches cmd_op encoding)
//   - state_e : main FSM states
// -----------------------------------------------------------------------------
package cmd_host_master_pkg;

  localparam logic [7:0] CMD_RF_WR   = 8'hAA;
  localparam logic [7:0] CMD_RF_RD   = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

  typedef enum logic [1:0] {
    OP_RF_WR   = 2'd0,
    OP_RF_RD   = 2'd1,
    OP_ALU_OP  = 2'd2,
    OP_ALU_NOP = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_HI  = 3'd2,
    WAIT_LO  = 3'd3,
    WAIT_RSP = 3'd4,
    DONE     = 3'd5
  } state_e;

endpackage

// File: rtl/cmd_host_master_if.sv
// -----------------------------------------------------------------------------
// cmd_host_master_if
// Bundles the command, UART transmit, UART receive and response signals of
// cmd_host_master.
//   master : view of the initiator (drives cmd_ready, tx_*, rsp_*)
//   slave  : view of the surrounding system (drives cmd_*, tx_busy, rx_*)
// -----------------------------------------------------------------------------
interface cmd_host_master_if;
  // command request
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [7:0]  cmd_data_a;
  logic [7:0]  cmd_data_b;
  logic [3:0]  cmd_fun;
  // UART transmitter side
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_busy;
  // UART receiver side
  logic [7:0]  rx_data;
  logic        rx_valid;
  // completion
  logic [15:0] rsp_data;
  logic        rsp_valid;
  logic        rsp_timeout;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
    input  tx_busy, rx_data, rx_valid,
    output cmd_ready, tx_data, tx_valid, rsp_data, rsp_valid, rsp_timeout
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_data_a, cmd_data_b, cmd_fun,
    output tx_busy, rx_data, rx_valid,
    input  cmd_ready, tx_data, tx_valid, rsp_data, rsp_valid, rsp_timeout
  );
endinterface

// File: rtl/cmd_host_master_frame_byte_mux.sv
// -----------------------------------------------------------------------------
// frame_byte_mux
// Combinational frame builder: from the captured command fields and the
// current byte index it returns the byte to transmit, the total frame length
// and the number of response bytes the command expects.
//   op_i, addr_i, data_a_i, data_b_i, fun_i : captured command fields
//   byte_cnt_i  : index of the frame byte being sent
//   byte_o      : frame byte at byte_cnt_i (0 beyond the frame end)
//   frame_len_o : number of frame bytes (2..4)
//   rsp_len_o   : number of response bytes (0..2)
// -----------------------------------------------------------------------------
module frame_byte_mux
  import cmd_host_master_pkg::*;
(
  input  op_e        op_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] data_a_i,
  input  logic [7:0] data_b_i,
  input  logic [3:0] fun_i,
  input  logic [1:0] byte_cnt_i,
  output logic [7:0] byte_o,
  output logic [2:0] frame_len_o,
  output logic [1:0] rsp_len_o
);

  logic [7:0] frame [4];

  always_comb begin
    frame[0]    = 8'h00;
    frame[1]    = 8'h00;
    frame[2]    = 8'h00;
    frame[3]    = 8'h00;
    frame_len_o = 3'd2;
    rsp_len_o   = 2'd0;
    case (op_i)
      OP_RF_WR: begin
        frame[0]    = CMD_RF_WR;
        frame[1]    = {4'h0, addr_i};
        frame[2]    = data_a_i;
        frame_len_o = 3'd3;
        rsp_len_o   = 2'd0;
      end
      OP_RF_RD: begin
        frame[0]    = CMD_RF_RD;
        frame[1]    = {4'h0, addr_i};
        frame_len_o = 3'd2;
        rsp_len_o   = 2'd1;
      end
      OP_ALU_OP: begin
        frame[0]    = CMD_ALU_OP;
        frame[1]    = data_a_i;
        frame[2]    = data_b_i;
        frame[3]    = {4'h0, fun_i};
        frame_len_o = 3'd4;
        rsp_len_o   = 2'd2;
      end
      OP_ALU_NOP: begin
        frame[0]    = CMD_ALU_NOP;
        frame[1]    = {4'h0, fun_i};
        frame_len_o = 3'd2;
        rsp_len_o   = 2'd2;
      end
      default: ;
    endcase
  end

  assign byte_o = frame[byte_cnt_i];

endmodule

// File: rtl/cmd_host_master.sv
// -----------------------------------------------------------------------------
// cmd_host_master
// Host-side initiator of the command-frame protocol. Accepts one command at a
// time, serialises its frame byte-wise to a UART transmitter (handshaking on
// tx_busy rise/fall per byte), collects the response bytes from the UART
// receiver and reports completion or a watchdog abort.
//   CLK, RST     : clock, asynchronous active-high reset
//   bus (master) : cmd_* request, tx_* transmit, rx_* receive, rsp_* result
// Parameters:
//   TIMEOUT_W      : watchdog counter width
//   TIMEOUT_CYCLES : cycles spent in a waiting state before aborting
// -----------------------------------------------------------------------------
module cmd_host_master
  import cmd_host_master_pkg::*;
#(
  parameter int                   TIMEOUT_W      = 16,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'hFFFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  cmd_host_master_if.master    bus
);

  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_CYCLES - 1'b1;

  state_e               state_q;
  op_e                  op_q;
  logic [3:0]           addr_q;
  logic [7:0]           data_a_q;
  logic [7:0]           data_b_q;
  logic [3:0]           fun_q;
  logic [1:0]           byte_cnt_q;
  logic                 rx_cnt_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] wd_d;
  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;
  logic [15:0]          rsp_data_q;
  logic                 rsp_valid_q;
  logic                 rsp_timeout_q;

  logic [7:0]           frame_byte;
  logic [2:0]           frame_len;
  logic [1:0]           rsp_len;
  logic                 last_byte;
  logic                 wd_expired;

  frame_byte_mux u_frame_byte_mux (
    .op_i        (op_q),
    .addr_i      (addr_q),
    .data_a_i    (data_a_q),
    .data_b_i    (data_b_q),
    .fun_i       (fun_q),
    .byte_cnt_i  (byte_cnt_q),
    .byte_o      (frame_byte),
    .frame_len_o (frame_len),
    .rsp_len_o   (rsp_len)
  );

  assign last_byte  = ({1'b0, byte_cnt_q} == (frame_len - 3'd1));
  assign wd_expired = (wd_q == WD_LAST);
  assign wd_d       = wd_q + 1'b1;

  // The timeout pulse cycle is still IDLE, but a command must not be taken
  // until the cycle after the pulse.
  assign bus.cmd_ready   = (state_q == IDLE) && !rsp_timeout_q;
  assign bus.tx_valid    = tx_valid_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_timeout = rsp_timeout_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      op_q          <= OP_RF_WR;
      addr_q        <= 4'h0;
      data_a_q      <= 8'h00;
      data_b_q      <= 8'h00;
      fun_q         <= 4'h0;
      byte_cnt_q    <= 2'd0;
      rx_cnt_q      <= 1'b0;
      wd_q          <= '0;
      tx_valid_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      rsp_data_q    <= 16'h0000;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      tx_valid_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;

      case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (bus.cmd_valid && !rsp_timeout_q) begin
            op_q       <= op_e'(bus.cmd_op);
            addr_q     <= bus.cmd_addr;
            data_a_q   <= bus.cmd_data_a;
            data_b_q   <= bus.cmd_data_b;
            fun_q      <= bus.cmd_fun;
            byte_cnt_q <= 2'd0;
            rx_cnt_q   <= 1'b0;
            rsp_data_q <= 16'h0000;
            state_q    <= SEND;
          end
        end

        SEND: begin
          wd_q <= '0;
          if (!bus.tx_busy) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= frame_byte;
            state_q    <= WAIT_HI;
          end
        end

        WAIT_HI: begin
          if (bus.tx_busy) begin
            wd_q    <= '0;
            state_q <= WAIT_LO;
          end else if (wd_expired) begin
            wd_q          <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end

        WAIT_LO: begin
          if (!bus.tx_busy) begin
            wd_q <= '0;
            if (!last_byte) begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
              state_q    <= SEND;
            end else if (rsp_len == 2'd0) begin
              // rsp_valid is raised on entry so it is high during DONE
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= WAIT_RSP;
            end
          end else if (wd_expired) begin
            wd_q          <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end

        WAIT_RSP: begin
          // an arriving byte takes priority over a simultaneous expiry
          if (bus.rx_valid) begin
            wd_q     <= '0;
            rx_cnt_q <= 1'b1;
            if (!rx_cnt_q) begin
              rsp_data_q[7:0] <= bus.rx_data;
            end else begin
              rsp_data_q[15:8] <= bus.rx_data;
            end
            if (({1'b0, rx_cnt_q} + 2'd1) == rsp_len) begin
              rsp_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end else if (wd_expired) begin
            wd_q          <= '0;
            rsp_timeout_q <= 1'b1;
            state_q       <= IDLE;
          end else begin
            wd_q <= wd_d;
          end
        end

        DONE: begin
          wd_q    <= '0;
          state_q <= IDLE;
        end

        default: begin
          wd_q    <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/cmd_host_master.md
CMD_HOST_MASTER -- requirements
Module: cmd_host_master

Interface
REQ-001 Parameter: TIMEOUT_W, 16, width of the watchdog counter.
REQ-002 Parameter: TIMEOUT_CYCLES, 16'hFFFF, watchdog limit in CLK cycles.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 Port: CLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: RST  in  1  asynchronous, active-high reset.
REQ-006 Port: cmd_valid  in  1  command request.
REQ-007 Port: cmd_ready  out  1  high only in IDLE.
REQ-008 Port: cmd_op  in  2  opcode: 0 = RF write, 1 = RF read, 2 = ALU with operands, 3 = ALU without operands.
REQ-009 Port: cmd_addr  in  4  register-file address.
REQ-010 Port: cmd_data_a  in  8  write data, or ALU operand A.
REQ-011 Port: cmd_data_b  in  8  ALU operand B.
REQ-012 Port: cmd_fun  in  4  ALU function.
REQ-013 Port: tx_data  out  8  byte to the UART transmitter.
REQ-014 Port: tx_valid  out  1  one-cycle byte strobe.
REQ-015 Port: tx_busy  in  1  UART transmitter busy flag.
REQ-016 Port: rx_data  in  8  response byte from the UART receiver.
REQ-017 Port: rx_valid  in  1  one-cycle response strobe.
REQ-018 Port: rsp_data  out  16  response payload.
REQ-019 Port: rsp_valid  out  1  one-cycle completion pulse.
REQ-020 Port: rsp_timeout  out  1  one-cycle watchdog abort pulse.

Function
REQ-021 The block SHALL be the host-side initiator of the command-frame protocol: serialise command frames byte-wise and collect responses.
REQ-022 Frame bytes and response lengths SHALL be:
- op0 (RF write): 0xAA, {4'h0,addr}, data_a; 0 response bytes.
- op1 (RF read): 0xBB, {4'h0,addr}; 1 response byte.
- op2 (ALU with operands): 0xCC, data_a, data_b, {4'h0,fun}; 2 response bytes.
- op3 (ALU without operands): 0xDD, {4'h0,fun}; 2 response bytes.
REQ-023 Acceptance: in IDLE with cmd_valid high, the block SHALL register all command fields, clear byte_cnt, and go to SEND; inputs are ignored outside IDLE.
REQ-024 States SHALL be IDLE, SEND, WAIT_HI, WAIT_LO, WAIT_RSP, DONE.
REQ-025 SEND: when tx_busy is low, tx_valid SHALL be high for exactly one cycle with tx_data = frame byte[byte_cnt], then go to WAIT_HI; while tx_busy is high, the block SHALL wait in SEND.
REQ-026 WAIT_HI: on tx_busy = 1, go to WAIT_LO.
REQ-027 WAIT_LO: on tx_busy = 0, go to the next state:
- last frame byte, response length 0: DONE;
- last frame byte, response length non-zero: WAIT_RSP;
- otherwise: byte_cnt+1, then SEND.
REQ-028 WAIT_RSP: each rx_valid SHALL store rx_data. For op1, the byte goes to rsp_data[7:0] and rsp_data[15:8] = 0. For ALU ops, the first byte goes to [7:0] and the second to [15:8]. After the last byte, go to DONE.
REQ-029 rx_valid outside WAIT_RSP SHALL be ignored.
REQ-030 DONE: rsp_valid high for one cycle, then IDLE. rsp_data SHALL be 0 for op0 and SHALL hold its value until the next accepted command.
REQ-031 Watchdog: the counter SHALL clear on every state change and count in WAIT_HI, WAIT_LO and WAIT_RSP. When it reaches TIMEOUT_CYCLES-1, the block SHALL pulse rsp_timeout for one cycle, not pulse rsp_valid, and go to IDLE.
REQ-032 If rx_valid and the watchdog expiry occur in the same cycle, rx_valid SHALL win and the watchdog counter SHALL clear.
REQ-033 Throughput: a new command SHALL be accepted no earlier than the cycle after rsp_valid or rsp_timeout.

Reset
REQ-034 RST high SHALL force IDLE immediately, including mid-frame.
REQ-035 Outputs during reset: cmd_ready = 1; tx_valid, rsp_valid, rsp_timeout = 0; tx_data = 0; rsp_data = 0; all counters = 0.
REQ-036 After RST deasserts, the first command SHALL be accepted on the first rising edge with cmd_valid high.

Structure
REQ-037 A shared package SHALL hold:
- frame constants CMD_RF_WR = 8'hAA, CMD_RF_RD = 8'hBB, CMD_ALU_OP = 8'hCC, CMD_ALU_NOP = 8'hDD;
- the opcode enumeration;
- the state enumeration.
REQ-038 A single sub-module, frame_byte_mux, SHALL be combinational: captured fields + byte_cnt -> frame byte, frame length, response length.

Verification
REQ-039 RF write, op0, addr 4'h5, data 8'h3C, tx_busy model 10 cycles per byte -> tx_data sequence AA, 05, 3C; rsp_valid once; rsp_data = 0.
REQ-040 RF read, op1, addr 4'h2, bench returns 8'h7E -> bytes BB, 02; rsp_data = 16'h007E.
REQ-041 ALU, op2, A = 8'h10, B = 8'h20, fun = 4'h0, responses 8'h30, 8'h00 -> bytes CC, 10, 20, 00; rsp_data = 16'h0030.
REQ-042 op3, fun = 4'h2, TIMEOUT_CYCLES = 50, no response -> rsp_timeout pulses 50 cycles after WAIT_RSP entry; no rsp_valid; cmd_ready returns high.
REQ-043 RST asserted during the second byte of op2 -> tx_valid = 0 and IDLE immediately; a following op1 runs cleanly.
REQ-044 tx_busy held high at SEND entry for 20 cycles, and a stray rx_valid in IDLE -> tx_valid issued only after busy falls; the stray byte is not reflected in rsp_data.
